regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 60 ++++++
 rtl/regfile_mp.sv | 107 ++++++++++
 tb/tb_regfile_mp.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default widths and
// the FSM state encoding used by regfile_mp.
package regfile_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by a reservation,
// cleared by a write, looked up by every read port.
module rf_scoreboard #(
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              rsv,
  input  logic [AW-1:0]     rsv_a,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD-1:0]    busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW-1:0]   look_a;
  logic            look_hit;
  logic            look_masked;

  // Clears first, reservation last, so a same-cycle reserve wins.
  // NOTE: blocking assignments inside always_comb build the next value in
  // order; the later statement overrides the earlier one for the same bit.
  always_comb begin
    busy_d = busy_q;
    if (we0) busy_d[wa0] = 1'b0;
    if (we1) busy_d[wa1] = 1'b0;
    if (rsv) busy_d[rsv_a] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs before any of them update.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    busy        = '0;
    look_a      = '0;
    look_hit    = 1'b0;
    look_masked = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      look_a      = ra[k*AW +: AW];
      look_hit    = (we0 && wa0 == look_a) || (we1 && wa1 == look_a);
      // A register being written this cycle is no longer pending unless it
      // is re-reserved in the same cycle.
      look_masked = (BYPASS != 0) && look_hit && !(rsv && rsv_a == look_a);
      busy[k]     = busy_q[look_a] && !look_masked;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, optional write-to-read
// forwarding, a pending-write scoreboard and a post-reset clear sequence.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN   = DEF_XLEN,
  parameter  int NREG   = DEF_NREG,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [NRD*AW-1:0]   RA,
  output logic [NRD*XLEN-1:0] RD,
  output logic [NRD-1:0]      BUSY,
  input  logic                WE0,
  input  logic [AW-1:0]       WA0,
  input  logic [XLEN-1:0]     WD0,
  input  logic                WE1,
  input  logic [AW-1:0]       WA1,
  input  logic [XLEN-1:0]     WD1,
  input  logic                RSV,
  input  logic [AW-1:0]       RSV_A,
  output logic                READY
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            ready;
  logic            we0_g, we1_g, rsv_g;
  logic [XLEN-1:0] mem [NREG];
  logic [AW-1:0]   rd_a;
  logic [XLEN-1:0] rd_v;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == CLEAR) begin
      if (idx_q == LAST_IDX) state_d = RUN;
      else                   idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign ready = (state_q == RUN);
  assign READY = ready;
  assign we0_g = WE0 && ready;
  assign we1_g = WE1 && ready;
  assign rsv_g = RSV && ready && (RSV_A != '0);

  // NOTE: the array has no reset so it maps onto RAM; the CLEAR walk is
  // what zeroes it. Port 1 is written last so it wins on an address clash.
  always_ff @(posedge CLK) begin
    if (state_q == CLEAR) begin
      mem[idx_q] <= '0;
    end else begin
      if (we0_g && WA0 != '0) mem[WA0] <= WD0;
      if (we1_g && WA1 != '0) mem[WA1] <= WD1;
    end
  end

  always_comb begin
    RD   = '0;
    rd_a = '0;
    rd_v = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_a = RA[k*AW +: AW];
      rd_v = mem[rd_a];
      if (BYPASS != 0) begin
        if (we1_g && WA1 == rd_a)      rd_v = WD1;
        else if (we0_g && WA0 == rd_a) rd_v = WD0;
      end
      if (!ready || rd_a == '0) rd_v = '0;
      RD[k*XLEN +: XLEN] = rd_v;
    end
  end

  rf_scoreboard #(
    .NREG   (NREG),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .rsv   (rsv_g),
    .rsv_a (RSV_A),
    .we0   (we0_g),
    .wa0   (WA0),
    .we1   (we1_g),
    .wa1   (WA1),
    .ra    (RA),
    .busy  (BUSY)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters
// (XLEN=32, NREG=32, NRD=2, BYPASS=1).
module tb_regfile_mp;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [9:0]  RA;
  logic [63:0] RD;
  logic [1:0]  BUSY;
  logic        WE0, WE1, RSV;
  logic [4:0]  WA0, WA1, RSV_A;
  logic [31:0] WD0, WD1;
  logic        READY;

  int total  = 0;
  int passed = 0;

  regfile_mp dut (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .RA    (RA),
    .RD    (RD),
    .BUSY  (BUSY),
    .WE0   (WE0),
    .WA0   (WA0),
    .WD0   (WD0),
    .WE1   (WE1),
    .WA1   (WA1),
    .WD1   (WD1),
    .RSV   (RSV),
    .RSV_A (RSV_A),
    .READY (READY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    WE0 = 1'b0; WA0 = '0; WD0 = '0;
    WE1 = 1'b0; WA1 = '0; WD1 = '0;
    RSV = 1'b0; RSV_A = '0;
  endtask

  // Called at a negedge right after RSTn rises; stray writes and a
  // reservation to register 4 are driven throughout and must be ignored.
  task automatic clear_seq();
    WE0 = 1'b1; WA0 = 5'd4; WD0 = 32'h1234_5678;
    RSV = 1'b1; RSV_A = 5'd4;
    RA  = {5'd4, 5'd4};
    #1;
    check("ready_c0", {31'd0, READY}, 32'd0);
    for (int i = 1; i < 32; i++) begin
      step();
      #1;
      check("ready_clr", {31'd0, READY}, 32'd0);
      check("rd_clr", RD[31:0] | RD[63:32], 32'd0);
      check("busy_clr", {30'd0, BUSY}, 32'd0);
    end
    step();
    check("ready_c32", {31'd0, READY}, 32'd1);
    idle_inputs();
    #1;
    check("rd4_clean", RD[31:0], 32'd0);
    check("busy4_clean", {31'd0, BUSY[0]}, 32'd0);
  endtask

  initial begin
    RSTn = 1'b0;
    RA   = '0;
    idle_inputs();
    step();
    step();
    check("rst_ready", {31'd0, READY}, 32'd0);
    check("rst_busy", {30'd0, BUSY}, 32'd0);
    check("rst_rd", RD[31:0] | RD[63:32], 32'd0);

    RSTn = 1'b1;
    clear_seq();

    // Same-cycle forwarding, then the stored value on later cycles.
    WE0 = 1'b1; WA0 = 5'd5; WD0 = 32'hDEAD_BEEF;
    RA  = {5'd0, 5'd5};
    #1;
    check("byp_5", RD[31:0], 32'hDEAD_BEEF);
    step();
    idle_inputs();
    #1;
    check("rd_5_c1", RD[31:0], 32'hDEAD_BEEF);
    step();
    RA = {5'd5, 5'd0};
    #1;
    check("rd_5_c2_p1", RD[63:32], 32'hDEAD_BEEF);

    // Dual write to the same address: port 1 wins.
    WE0 = 1'b1; WA0 = 5'd7; WD0 = 32'h11;
    WE1 = 1'b1; WA1 = 5'd7; WD1 = 32'h22;
    RA  = {5'd5, 5'd7};
    #1;
    check("byp_7", RD[31:0], 32'h22);
    step();
    idle_inputs();
    #1;
    check("rd_7", RD[31:0], 32'h22);
    check("rd_5_kept", RD[63:32], 32'hDEAD_BEEF);

    // Register 0 is hardwired to zero and never reservable.
    WE0 = 1'b1; WA0 = 5'd0; WD0 = 32'hFFFF_FFFF;
    RA  = {5'd0, 5'd0};
    #1;
    check("byp_0", RD[31:0], 32'd0);
    step();
    idle_inputs();
    RSV = 1'b1; RSV_A = 5'd0;
    #1;
    check("rd_0", RD[31:0], 32'd0);
    step();
    idle_inputs();
    #1;
    check("busy_0", {31'd0, BUSY[0]}, 32'd0);

    // Reserve 9, write it two cycles later.
    RA  = {5'd5, 5'd9};
    RSV = 1'b1; RSV_A = 5'd9;
    #1;
    check("busy9_pre", {31'd0, BUSY[0]}, 32'd0);
    step();
    idle_inputs();
    #1;
    check("busy9_c1", {31'd0, BUSY[0]}, 32'd1);
    check("busy5_c1", {31'd0, BUSY[1]}, 32'd0);
    step();
    #1;
    check("busy9_c2", {31'd0, BUSY[0]}, 32'd1);
    WE1 = 1'b1; WA1 = 5'd9; WD1 = 32'h99;
    #1;
    check("busy9_wr", {31'd0, BUSY[0]}, 32'd0);
    check("byp_9", RD[31:0], 32'h99);
    step();
    idle_inputs();
    #1;
    check("busy9_done", {31'd0, BUSY[0]}, 32'd0);
    check("rd_9", RD[31:0], 32'h99);

    // Reserve and write 9 in the same cycle: reservation wins.
    RSV = 1'b1; RSV_A = 5'd9;
    WE0 = 1'b1; WA0 = 5'd9; WD0 = 32'hAB;
    step();
    idle_inputs();
    #1;
    check("busy9_both", {31'd0, BUSY[0]}, 32'd1);
    check("rd_9_both", RD[31:0], 32'hAB);

    // Mark register 3 busy with data, then reset mid-RUN.
    RSV = 1'b1; RSV_A = 5'd3;
    WE0 = 1'b1; WA0 = 5'd3; WD0 = 32'h33;
    step();
    idle_inputs();
    RA = {5'd9, 5'd3};
    #1;
    check("busy3_set", {31'd0, BUSY[0]}, 32'd1);
    check("rd_3", RD[31:0], 32'h33);
    RSTn = 1'b0;
    #1;
    check("rst2_busy", {30'd0, BUSY}, 32'd0);
    check("rst2_ready", {31'd0, READY}, 32'd0);
    check("rst2_rd", RD[31:0] | RD[63:32], 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    clear_seq();
    RA = {5'd9, 5'd3};
    #1;
    check("rd_3_cleared", RD[31:0], 32'd0);
    check("rd_9_cleared", RD[63:32], 32'd0);
    check("busy_after_rst", {30'd0, BUSY}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
